// File: rtl/cv32e40s_instr_obi_responder.sv
// OBI instruction-side responder: grants fetches, queues them in order, reads a
// 1-cycle synchronous memory and returns responses with parity/checksum signals.
module cv32e40s_instr_obi_responder #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] ADDR_LIMIT      = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        reqpar_i,
   input  logic [31:0] addr_i,
   input  logic [2:0]  prot_i,
   input  logic [1:0]  memtype_i,
   input  logic        dbg_i,
   input  logic [12:0] achk_i,
   output logic        gnt_o,
   output logic        gntpar_o,
   output logic        rvalid_o,
   output logic        rvalidpar_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [4:0]  rchk_o,
   input  logic        gnt_stall_i,
   input  logic        resp_stall_i,
   output logic        mem_req_o,
   output logic [29:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   output logic        integrity_err_o,
   output logic        protocol_err_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned AW = 32 + 3 + 2 + 1 + 13;

   logic [29:0]   r_fifoAddr [MAX_OUTSTANDING];
   logic          r_fifoErr  [MAX_OUTSTANDING];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_occ;
   logic [CW-1:0] r_cnt;
   logic          r_pending;
   logic          r_respErr;
   logic          r_integrityErr;
   logic          r_protocolErr;
   logic          r_stalledReq;
   logic [AW-1:0] r_prevA;

   logic          w_slotFree;
   logic          w_push;
   logic          w_pop;
   logic          w_headErr;
   logic [29:0]   w_headAddr;
   logic [12:0]   w_achkExp;
   logic [AW-1:0] w_curA;
   logic          w_integrityHit;
   logic          w_protocolHit;

   // A response leaving this cycle frees its slot immediately, which keeps
   // grants flowing back-to-back when the pipeline is full.
   assign w_slotFree = (r_cnt < CW'(MAX_OUTSTANDING)) || r_pending;
   assign gnt_o      = req_i && !gnt_stall_i && !rst && w_slotFree;
   assign gntpar_o   = ~gnt_o;
   assign w_push     = gnt_o;

   assign w_headAddr = r_fifoAddr[r_rdPtr];
   assign w_headErr  = r_fifoErr[r_rdPtr];
   assign w_pop      = (r_occ != '0) && !resp_stall_i && !rst;
   assign mem_req_o  = w_pop && !w_headErr;
   assign mem_addr_o = w_pop ? w_headAddr : 30'd0;

   assign rvalid_o    = r_pending;
   assign rvalidpar_o = ~rvalid_o;
   assign err_o       = r_pending && r_respErr;
   assign rdata_o     = (r_pending && !r_respErr) ? mem_rdata_i : 32'd0;
   assign rchk_o      = {err_o, ^rdata_o[31:24], ^rdata_o[23:16], ^rdata_o[15:8], ^rdata_o[7:0]};

   // Bit 5 covers be=4'b1111 and we=0, whose inverted parity is constant 1.
   assign w_achkExp = {4'b0000, ~dbg_i, 1'b0, 1'b0, 1'b1, ~^{prot_i, memtype_i},
                       ^addr_i[31:24], ^addr_i[23:16], ^addr_i[15:8], ^addr_i[7:2]};

   assign w_curA         = {addr_i, prot_i, memtype_i, dbg_i, achk_i};
   assign w_integrityHit = (reqpar_i == req_i) || (req_i && (achk_i != w_achkExp));
   assign w_protocolHit  = r_stalledReq && (!req_i || (w_curA != r_prevA));

   assign integrity_err_o = r_integrityErr;
   assign protocol_err_o  = r_protocolErr;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoAddr[r_wrPtr] <= addr_i[31:2];
         r_fifoErr[r_wrPtr]  <= (addr_i >= ADDR_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_occ     <= '0;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_respErr <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= (r_wrPtr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rdPtr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_occ <= r_occ + CW'(1);
         end else if (w_pop && !w_push) begin
            r_occ <= r_occ - CW'(1);
         end
         case ({w_push, r_pending})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         r_pending <= w_pop;
         r_respErr <= w_pop && w_headErr;
      end
   end

   // Sticky violation monitors; a stalled request must hold its A-channel steady.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_integrityErr <= 1'b0;
         r_protocolErr  <= 1'b0;
         r_stalledReq   <= 1'b0;
         r_prevA        <= '0;
      end else begin
         r_integrityErr <= r_integrityErr || w_integrityHit;
         r_protocolErr  <= r_protocolErr || w_protocolHit;
         r_stalledReq   <= req_i && !gnt_o;
         r_prevA        <= w_curA;
      end
   end

endmodule

// File: tb/tb_cv32e40s_instr_obi_responder.sv
// Directed bench for the OBI instruction responder: queue-based reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_cv32e40s_instr_obi_responder;

   localparam int unsigned MAX   = 2;
   localparam logic [31:0] LIMIT = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i = 1'b0;
   logic        reqpar_i = 1'b1;
   logic [31:0] addr_i = 32'd0;
   logic [2:0]  prot_i = 3'b110;
   logic [1:0]  memtype_i = 2'b01;
   logic        dbg_i = 1'b0;
   logic [12:0] achk_i = 13'd0;
   logic        gnt_stall_i = 1'b0;
   logic        resp_stall_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'd0;
   logic        gnt_o, gntpar_o, rvalid_o, rvalidpar_o, err_o, mem_req_o;
   logic        integrity_err_o, protocol_err_o;
   logic [31:0] rdata_o;
   logic [4:0]  rchk_o;
   logic [29:0] mem_addr_o;

   int testsRun = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cv32e40s_instr_obi_responder #(
      .MAX_OUTSTANDING(MAX),
      .ADDR_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .reqpar_i(reqpar_i), .addr_i(addr_i),
      .prot_i(prot_i), .memtype_i(memtype_i), .dbg_i(dbg_i), .achk_i(achk_i),
      .gnt_o(gnt_o), .gntpar_o(gntpar_o), .rvalid_o(rvalid_o), .rvalidpar_o(rvalidpar_o),
      .rdata_o(rdata_o), .err_o(err_o), .rchk_o(rchk_o), .gnt_stall_i(gnt_stall_i),
      .resp_stall_i(resp_stall_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_rdata_i(mem_rdata_i), .integrity_err_o(integrity_err_o),
      .protocol_err_o(protocol_err_o)
   );

   function automatic logic [31:0] memWord(input logic [29:0] wa);
      return (wa == 30'h40) ? 32'h0000_0013 : {wa[15:0] ^ 16'h5A5A, wa[15:0]};
   endfunction

   function automatic logic [12:0] tbAchk(input logic [31:0] a, input logic [2:0] p,
                                          input logic [1:0] m, input logic d);
      logic [12:0] c;
      c = 13'd0;
      c[8] = ~d;
      c[5] = ~^{4'b1111, 1'b0};
      c[4] = ~^{p, m};
      c[3] = ^a[31:24];
      c[2] = ^a[23:16];
      c[1] = ^a[15:8];
      c[0] = ^{a[7:2], 2'b00};
      return c;
   endfunction

   // Synchronous 1-cycle memory; idle cycles return a poison word.
   always @(posedge clk) begin
      mem_rdata_i <= mem_req_o ? memWord(mem_addr_o) : 32'hDEAD_BEEF;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rq, input logic [31:0] a,
                                input logic gs, input logic rs, input logic badAchk,
                                input logic badPar);
      @(posedge clk);
      #1;
      rst          = r;
      req_i        = rq;
      addr_i       = a;
      prot_i       = 3'b110;
      memtype_i    = 2'b01;
      dbg_i        = 1'b0;
      achk_i       = tbAchk(a, 3'b110, 2'b01, 1'b0) ^ {12'd0, badAchk};
      reqpar_i     = badPar ? rq : ~rq;
      gnt_stall_i  = gs;
      resp_stall_i = rs;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reference model: grants wait in a queue, leave it one per unstalled cycle,
   // and are answered in the cycle after they leave.
   typedef struct {
      logic [29:0] wa;
      logic        err;
   } entry_t;

   entry_t      q[$];
   entry_t      due;
   logic        dueValid = 1'b0;
   logic        mInteg = 1'b0;
   logic        mProto = 1'b0;
   logic        mPrevStall = 1'b0;
   logic [50:0] mPrevA = '0;
   logic        expGnt, expRv, expErr, expMemReq, popping;
   logic [31:0] expData;
   logic [4:0]  expRchk;
   logic [50:0] curA;
   int          outstanding;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         dueValid   = 1'b0;
         mInteg     = 1'b0;
         mProto     = 1'b0;
         mPrevStall = 1'b0;
         mPrevA     = '0;
      end else begin
         expRv       = dueValid;
         expErr      = dueValid && due.err;
         expData     = (dueValid && !due.err) ? memWord(due.wa) : 32'd0;
         expRchk     = {expErr, ^expData[31:24], ^expData[23:16], ^expData[15:8], ^expData[7:0]};
         outstanding = q.size() + (dueValid ? 1 : 0);
         expGnt      = req_i && !gnt_stall_i && ((outstanding < int'(MAX)) || dueValid);
         popping     = (q.size() > 0) && !resp_stall_i;
         expMemReq   = popping && !q[0].err;

         checkOutput("m_gnt", {31'd0, gnt_o}, {31'd0, expGnt});
         checkOutput("m_gntpar", {31'd0, gntpar_o}, {31'd0, ~expGnt});
         checkOutput("m_rvalid", {31'd0, rvalid_o}, {31'd0, expRv});
         checkOutput("m_rvalidpar", {31'd0, rvalidpar_o}, {31'd0, ~expRv});
         checkOutput("m_rdata", rdata_o, expData);
         checkOutput("m_err", {31'd0, err_o}, {31'd0, expErr});
         checkOutput("m_rchk", {27'd0, rchk_o}, {27'd0, expRchk});
         checkOutput("m_memreq", {31'd0, mem_req_o}, {31'd0, expMemReq});
         if (expMemReq) begin
            checkOutput("m_memaddr", {2'd0, mem_addr_o}, {2'd0, q[0].wa});
         end
         checkOutput("m_integ", {31'd0, integrity_err_o}, {31'd0, mInteg});
         checkOutput("m_proto", {31'd0, protocol_err_o}, {31'd0, mProto});

         curA   = {addr_i, prot_i, memtype_i, dbg_i, achk_i};
         mInteg = mInteg || (reqpar_i == req_i) ||
                  (req_i && (achk_i != tbAchk(addr_i, prot_i, memtype_i, dbg_i)));
         mProto = mProto || (mPrevStall && (!req_i || (curA != mPrevA)));
         mPrevStall = req_i && !expGnt;
         mPrevA     = curA;

         if (popping) begin
            due      = q.pop_front();
            dueValid = 1'b1;
         end else begin
            dueValid = 1'b0;
         end
         if (expGnt) begin
            q.push_back('{wa: addr_i[31:2], err: (addr_i >= LIMIT)});
         end
      end
   end

   initial begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("rst_gnt", {31'd0, gnt_o}, 32'd0);
      checkOutput("rst_gntpar", {31'd0, gntpar_o}, 32'd1);
      checkOutput("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      checkOutput("rst_rvalidpar", {31'd0, rvalidpar_o}, 32'd1);
      checkOutput("rst_rdata", rdata_o, 32'd0);
      checkOutput("rst_rchk", {27'd0, rchk_o}, 32'd0);
      checkOutput("rst_memreq", {31'd0, mem_req_o}, 32'd0);
      checkOutput("rst_integ", {31'd0, integrity_err_o}, 32'd0);
      checkOutput("rst_proto", {31'd0, protocol_err_o}, 32'd0);

      // Single fetch
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("single_gnt", {31'd0, gnt_o}, 32'd1);
      idle();
      checkOutput("single_memreq", {31'd0, mem_req_o}, 32'd1);
      checkOutput("single_memaddr", {2'd0, mem_addr_o}, 32'h40);
      idle();
      checkOutput("single_rvalid", {31'd0, rvalid_o}, 32'd1);
      checkOutput("single_rdata", rdata_o, 32'h0000_0013);
      checkOutput("single_err", {31'd0, err_o}, 32'd0);
      checkOutput("single_rchk", {27'd0, rchk_o}, 32'h01);
      checkOutput("single_rvalidpar", {31'd0, rvalidpar_o}, 32'd0);
      idle();

      // Back-to-back fetches
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_gnt0", {31'd0, gnt_o}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_gnt1", {31'd0, gnt_o}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_gnt2", {31'd0, gnt_o}, 32'd1);
      checkOutput("b2b_rdata0", rdata_o, 32'h5A5A_0000);
      idle();
      checkOutput("b2b_rdata1", rdata_o, 32'h5A5B_0001);
      idle();
      checkOutput("b2b_rdata2", rdata_o, 32'h5A58_0002);
      idle();

      // Fill under response stall, then release
      applyStimulus(1'b0, 1'b1, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hC4, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hC8, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("full_gnt", {31'd0, gnt_o}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("release_gnt", {31'd0, gnt_o}, 32'd0);
      checkOutput("release_memaddr", {2'd0, mem_addr_o}, 32'h30);
      applyStimulus(1'b0, 1'b1, 32'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("coincide_gnt", {31'd0, gnt_o}, 32'd1);
      checkOutput("coincide_rdata", rdata_o, 32'h5A6A_0030);
      idle();
      checkOutput("stall_rdata1", rdata_o, 32'h5A6B_0031);
      idle();
      checkOutput("stall_rdata2", rdata_o, 32'h5A68_0032);
      idle();

      // Out-of-range fetch
      applyStimulus(1'b0, 1'b1, LIMIT, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("limit_gnt", {31'd0, gnt_o}, 32'd1);
      idle();
      checkOutput("limit_memreq", {31'd0, mem_req_o}, 32'd0);
      idle();
      checkOutput("limit_rvalid", {31'd0, rvalid_o}, 32'd1);
      checkOutput("limit_err", {31'd0, err_o}, 32'd1);
      checkOutput("limit_rdata", rdata_o, 32'd0);
      checkOutput("limit_rchk", {27'd0, rchk_o}, 32'h10);
      idle();

      // Integrity: corrupted achk, then reqpar equal to req
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("achk_integ_pre", {31'd0, integrity_err_o}, 32'd0);
      idle();
      checkOutput("achk_integ", {31'd0, integrity_err_o}, 32'd1);
      idle();
      idle();
      checkOutput("achk_integ_held", {31'd0, integrity_err_o}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("integ_cleared", {31'd0, integrity_err_o}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("par_integ", {31'd0, integrity_err_o}, 32'd1);

      // Protocol violation, then reset with two outstanding
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("gstall_gnt", {31'd0, gnt_o}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("proto_pre", {31'd0, protocol_err_o}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("proto_set", {31'd0, protocol_err_o}, 32'd1);
      checkOutput("proto_gnt2", {31'd0, gnt_o}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("post_rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      checkOutput("post_rst_memreq", {31'd0, mem_req_o}, 32'd0);
      checkOutput("post_rst_proto", {31'd0, protocol_err_o}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_gnt", {31'd0, gnt_o}, 32'd1);
      checkOutput("post_rst_rvalid2", {31'd0, rvalid_o}, 32'd0);
      idle();
      checkOutput("post_rst_memaddr", {2'd0, mem_addr_o}, 32'h100);
      idle();
      checkOutput("post_rst_rdata", rdata_o, 32'h5B5A_0100);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
